// File: rtl/decode.sv
// decode: RV32I decode stage with built-in IF/ID pipeline register.
// Latches the fetch pc/instr pair, then decodes the latched word into register
// fields, a sign-extended immediate, execute control flags and an illegal flag.
// Optional feature macro: DECODE_HAZARD_EN enables load-use hazard detection.
// Without it the hazard term is tied low and forwarding is left to execute.
//
// Handshake: in_valid qualifies in_pc/in_instr. stall_fetch is the inverse
// of ready. A word is accepted on a rising edge only when stall_fetch=0 and
// flush=0. While stall_fetch=1, fetch must keep presenting the same word.
// out_valid qualifies the decoded outputs towards execute.

module decode #(
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_instr,
    input  logic        stall_in,
    input  logic        flush,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rd,
    output logic        stall_fetch,
    output logic        out_valid,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic [2:0]  funct3,
    output logic [6:0]  funct7,
    output logic [31:0] imm,
    output logic        reg_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        branch,
    output logic        jump,
    output logic        alu_src,
    output logic        illegal
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    logic        r_valid;
    logic [31:0] r_pc;
    logic [31:0] r_instr;

    logic [6:0]  w_opcode;
    logic        w_is_lui, w_is_auipc, w_is_jal, w_is_jalr, w_is_branch;
    logic        w_is_load, w_is_store, w_is_opimm, w_is_op, w_is_system;
    logic        w_legal;
    logic        w_hazard;
    logic        w_out_valid;
    logic        w_rd_nz;
    logic [31:0] w_imm;

    // IF/ID register: reset > flush > hold > load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_pc    <= 32'h0;
            r_instr <= NOP_INSTR;
        end else if (flush) begin
            r_valid <= 1'b0;
            r_instr <= NOP_INSTR;
        end else if (!stall_fetch) begin
            r_valid <= in_valid;
            r_pc    <= in_pc;
            r_instr <= in_instr;
        end
    end

    assign w_opcode    = r_instr[6:0];
    assign w_is_lui    = (w_opcode == OP_LUI);
    assign w_is_auipc  = (w_opcode == OP_AUIPC);
    assign w_is_jal    = (w_opcode == OP_JAL);
    assign w_is_jalr   = (w_opcode == OP_JALR);
    assign w_is_branch = (w_opcode == OP_BRANCH);
    assign w_is_load   = (w_opcode == OP_LOAD);
    assign w_is_store  = (w_opcode == OP_STORE);
    assign w_is_opimm  = (w_opcode == OP_OPIMM);
    assign w_is_op     = (w_opcode == OP_OP);
    assign w_is_system = (w_opcode == OP_SYSTEM);

    // The low-bit test is redundant with the opcode match but states the
    // compressed-encoding rejection explicitly.
    assign w_legal = (r_instr[1:0] == 2'b11) &
                     (w_is_lui | w_is_auipc | w_is_jal | w_is_jalr | w_is_branch |
                      w_is_load | w_is_store | w_is_opimm | w_is_op | w_is_system);

    assign rs1     = r_instr[19:15];
    assign rs2     = r_instr[24:20];
    assign rd      = r_instr[11:7];
    assign funct3  = r_instr[14:12];
    assign funct7  = r_instr[31:25];
    assign w_rd_nz = (r_instr[11:7] != 5'd0);

`ifdef DECODE_HAZARD_EN
    logic w_uses_rs1;
    logic w_uses_rs2;
    assign w_uses_rs1 = ~(w_is_lui | w_is_auipc | w_is_jal);
    assign w_uses_rs2 = w_is_branch | w_is_store | w_is_op;
    assign w_hazard   = r_valid & ex_mem_read & (ex_rd != 5'd0) &
                        ((w_uses_rs1 & (rs1 == ex_rd)) |
                         (w_uses_rs2 & (rs2 == ex_rd)));
`else
    // Load-use detection disabled: the execute-side inputs are intentionally unused.
    logic w_unused_ex;
    assign w_unused_ex = ^{ex_mem_read, ex_rd};
    assign w_hazard    = 1'b0;
`endif

    assign stall_fetch = stall_in | w_hazard;
    assign w_out_valid = r_valid & ~w_hazard;
    assign out_valid   = w_out_valid;
    assign out_pc      = r_pc;
    assign out_instr   = r_instr;

    // Immediate generation by instruction format; sign bit always instr[31].
    always_comb begin
        w_imm = 32'h0;
        if (w_is_load | w_is_opimm | w_is_jalr)
            w_imm = {{20{r_instr[31]}}, r_instr[31:20]};
        else if (w_is_store)
            w_imm = {{20{r_instr[31]}}, r_instr[31:25], r_instr[11:7]};
        else if (w_is_branch)
            w_imm = {{19{r_instr[31]}}, r_instr[31], r_instr[7],
                     r_instr[30:25], r_instr[11:8], 1'b0};
        else if (w_is_lui | w_is_auipc)
            w_imm = {r_instr[31:12], 12'h000};
        else if (w_is_jal)
            w_imm = {{11{r_instr[31]}}, r_instr[31], r_instr[19:12],
                     r_instr[20], r_instr[30:21], 1'b0};
    end
    assign imm = w_imm;

    // Control flags, all gated by out_valid so bubbles carry no side effects.
    always_comb begin
        reg_write = w_out_valid & w_rd_nz &
                    (w_is_lui | w_is_auipc | w_is_jal | w_is_jalr |
                     w_is_load | w_is_opimm | w_is_op);
        mem_read  = w_out_valid & w_is_load;
        mem_write = w_out_valid & w_is_store;
        branch    = w_out_valid & w_is_branch;
        jump      = w_out_valid & (w_is_jal | w_is_jalr);
        alu_src   = w_out_valid & (w_is_load | w_is_store | w_is_opimm |
                                   w_is_jalr | w_is_lui | w_is_auipc);
        illegal   = w_out_valid & ~w_legal;
    end

endmodule

// File: tb/tb_decode.sv
// tb_decode: directed vector bench for the decode stage.
module tb_decode;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic        stall_in;
    logic        flush;
    logic        ex_mem_read;
    logic [4:0]  ex_rd;
    logic        stall_fetch;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic        reg_write, mem_read, mem_write, branch, jump, alu_src, illegal;

    int total = 0;
    int bad   = 0;

    decode dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_pc(in_pc),
        .in_instr(in_instr), .stall_in(stall_in), .flush(flush),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .stall_fetch(stall_fetch),
        .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr),
        .rs1(rs1), .rs2(rs2), .rd(rd), .funct3(funct3), .funct7(funct7),
        .imm(imm), .reg_write(reg_write), .mem_read(mem_read),
        .mem_write(mem_write), .branch(branch), .jump(jump),
        .alu_src(alu_src), .illegal(illegal)
    );

    // Clock: 10 time-unit period, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    // flags packed as {illegal, reg_write, mem_read, mem_write, branch, jump, alu_src}
    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        vld;
        logic [4:0]  e_rd;
        logic [4:0]  e_rs1;
        logic [4:0]  e_rs2;
        logic [2:0]  e_f3;
        logic [6:0]  e_f7;
        logic [31:0] e_imm;
        logic [6:0]  e_flags;
    } vec_t;

    vec_t vecs[14];

    function automatic logic [6:0] flags_now();
        return {illegal, reg_write, mem_read, mem_write, branch, jump, alu_src};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [31:0] w, input logic [31:0] pc);
        in_valid = 1'b1;
        in_instr = w;
        in_pc    = pc;
        step();
    endtask

    initial begin
        vecs[0]  = '{32'h00500093, 32'h00, 1'b1, 5'd1,  5'd0,  5'd5,  3'd0, 7'h00, 32'h00000005, 7'b0100001}; // addi x1,x0,5
        vecs[1]  = '{32'hFE208CE3, 32'h10, 1'b1, 5'd25, 5'd1,  5'd2,  3'd0, 7'h7F, 32'hFFFFFFF8, 7'b0000100}; // beq x1,x2,-8
        vecs[2]  = '{32'h00812283, 32'h14, 1'b1, 5'd5,  5'd2,  5'd8,  3'd2, 7'h00, 32'h00000008, 7'b0110001}; // lw x5,8(x2)
        vecs[3]  = '{32'hFE612E23, 32'h18, 1'b1, 5'd28, 5'd2,  5'd6,  3'd2, 7'h7F, 32'hFFFFFFFC, 7'b0001001}; // sw x6,-4(x2)
        vecs[4]  = '{32'h123453B7, 32'h1C, 1'b1, 5'd7,  5'd8,  5'd3,  3'd5, 7'h09, 32'h12345000, 7'b0100001}; // lui x7,0x12345
        vecs[5]  = '{32'h010000EF, 32'h20, 1'b1, 5'd1,  5'd0,  5'd16, 3'd0, 7'h00, 32'h00000010, 7'b0100010}; // jal x1,+16
        vecs[6]  = '{32'h00008067, 32'h24, 1'b1, 5'd0,  5'd1,  5'd0,  3'd0, 7'h00, 32'h00000000, 7'b0000011}; // jalr x0,0(x1)
        vecs[7]  = '{32'h00000073, 32'h28, 1'b1, 5'd0,  5'd0,  5'd0,  3'd0, 7'h00, 32'h00000000, 7'b0000000}; // ecall
        vecs[8]  = '{32'hFFFFFFFF, 32'h2C, 1'b1, 5'd31, 5'd31, 5'd31, 3'd7, 7'h7F, 32'h00000000, 7'b1000000}; // illegal
        vecs[9]  = '{32'h00000000, 32'h30, 1'b1, 5'd0,  5'd0,  5'd0,  3'd0, 7'h00, 32'h00000000, 7'b1000000}; // illegal
        vecs[10] = '{32'hFFFFF517, 32'h34, 1'b1, 5'd10, 5'd31, 5'd31, 3'd7, 7'h7F, 32'hFFFFF000, 7'b0100001}; // auipc x10
        vecs[11] = '{32'h002081B3, 32'h38, 1'b1, 5'd3,  5'd1,  5'd2,  3'd0, 7'h00, 32'h00000000, 7'b0100000}; // add x3,x1,x2
        vecs[12] = '{32'h0000000F, 32'h3C, 1'b1, 5'd0,  5'd0,  5'd0,  3'd0, 7'h00, 32'h00000000, 7'b1000000}; // fence: unsupported
        vecs[13] = '{32'h00812283, 32'h40, 1'b0, 5'd5,  5'd2,  5'd8,  3'd2, 7'h00, 32'h00000008, 7'b0000000}; // lw, not valid

        // Reset state, asserted between edges.
        in_valid = 0; in_pc = 0; in_instr = 32'h0; stall_in = 0; flush = 0;
        ex_mem_read = 0; ex_rd = 0;
        reset = 0;
        #2 reset = 1;
        #1;
        chk("rst_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_instr", out_instr, 32'h00000013);
        chk("rst_pc", out_pc, 32'h0);
        chk("rst_stall", {31'h0, stall_fetch}, 32'h0);
        step();
        #4 reset = 0;

        // Table-driven decode vectors.
        for (int i = 0; i < 14; i++) begin
            in_valid = vecs[i].vld;
            in_instr = vecs[i].instr;
            in_pc    = vecs[i].pc;
            step();
            chk($sformatf("v%0d_valid", i), {31'h0, out_valid}, {31'h0, vecs[i].vld});
            chk($sformatf("v%0d_pc", i), out_pc, vecs[i].pc);
            chk($sformatf("v%0d_instr", i), out_instr, vecs[i].instr);
            chk($sformatf("v%0d_fields", i), {8'h0, rd, rs1, rs2, funct3, funct7},
                {8'h0, vecs[i].e_rd, vecs[i].e_rs1, vecs[i].e_rs2, vecs[i].e_f3, vecs[i].e_f7});
            chk($sformatf("v%0d_imm", i), imm, vecs[i].e_imm);
            chk($sformatf("v%0d_flags", i), {25'h0, flags_now()}, {25'h0, vecs[i].e_flags});
            chk($sformatf("v%0d_stall", i), {31'h0, stall_fetch}, 32'h0);
        end

        // Load-use: add x3,x1,x2 with a load to x1 in execute.
        load_word(32'h002081B3, 32'h80);
        ex_mem_read = 1; ex_rd = 5'd1;
        #1;
`ifdef DECODE_HAZARD_EN
        chk("lu_valid", {31'h0, out_valid}, 32'h0);
        chk("lu_stall", {31'h0, stall_fetch}, 32'h1);
        chk("lu_flags", {25'h0, flags_now()}, 32'h0);
        in_instr = 32'h00500093; in_pc = 32'h84;
        step();
        chk("lu_hold_instr", out_instr, 32'h002081B3);
        chk("lu_hold_pc", out_pc, 32'h80);
        ex_mem_read = 0;
        #1;
        chk("lu_release_valid", {31'h0, out_valid}, 32'h1);
        chk("lu_release_stall", {31'h0, stall_fetch}, 32'h0);
        chk("lu_release_instr", out_instr, 32'h002081B3);
        step();
        chk("lu_next_instr", out_instr, 32'h00500093);
        // rs2 match on an R-type also stalls.
        load_word(32'h002081B3, 32'h88);
        ex_mem_read = 1; ex_rd = 5'd2;
        #1;
        chk("lu_rs2_stall", {31'h0, stall_fetch}, 32'h1);
        // x0 destination never stalls.
        ex_rd = 5'd0;
        #1;
        chk("lu_x0_valid", {31'h0, out_valid}, 32'h1);
        // I-type: rs2 field equals ex_rd but is not a source.
        ex_mem_read = 0;
        load_word(32'h00500093, 32'h8C);
        ex_mem_read = 1; ex_rd = 5'd5;
        #1;
        chk("lu_itype_rs2_stall", {31'h0, stall_fetch}, 32'h0);
        // Flush coincident with a hazard drops valid and the hazard.
        ex_mem_read = 0;
        load_word(32'h002081B3, 32'h90);
        ex_mem_read = 1; ex_rd = 5'd1; flush = 1;
        #1;
        chk("fh_stall_before", {31'h0, stall_fetch}, 32'h1);
        step();
        flush = 0;
        chk("fh_valid", {31'h0, out_valid}, 32'h0);
        chk("fh_stall_after", {31'h0, stall_fetch}, 32'h0);
        chk("fh_instr", out_instr, 32'h00000013);
        // Reset mid-hazard clears the stall at once.
        ex_mem_read = 0;
        load_word(32'h002081B3, 32'h94);
        ex_mem_read = 1; ex_rd = 5'd1;
        #1;
        chk("rh_stall_before", {31'h0, stall_fetch}, 32'h1);
        #1 reset = 1;
        #1;
        chk("rh_stall", {31'h0, stall_fetch}, 32'h0);
        chk("rh_instr", out_instr, 32'h00000013);
        #1 reset = 0;
`else
        chk("lu_valid", {31'h0, out_valid}, 32'h1);
        chk("lu_stall", {31'h0, stall_fetch}, 32'h0);
        chk("lu_flags", {25'h0, flags_now()}, 32'h00000020);
`endif
        ex_mem_read = 0; ex_rd = 0;

        // Flush over stall: a held lw is squashed.
        load_word(32'h00812283, 32'hA0);
        stall_in = 1;
        in_instr = 32'hFFFFFFFF; in_pc = 32'hA4;
        #1;
        chk("fs_stall", {31'h0, stall_fetch}, 32'h1);
        step();
        chk("fs_hold_instr", out_instr, 32'h00812283);
        chk("fs_hold_mem_read", {31'h0, mem_read}, 32'h1);
        flush = 1;
        step();
        flush = 0;
        chk("fs_valid", {31'h0, out_valid}, 32'h0);
        chk("fs_instr", out_instr, 32'h00000013);
        chk("fs_flags", {25'h0, flags_now()}, 32'h0);
        chk("fs_pc_kept", out_pc, 32'hA0);

        // Reset mid-stall: stall_fetch follows stall_in only.
        load_word(32'h00500093, 32'hB0);
        #1 reset = 1;
        #1;
        chk("rs_stall", {31'h0, stall_fetch}, 32'h1);
        chk("rs_valid", {31'h0, out_valid}, 32'h0);
        chk("rs_pc", out_pc, 32'h0);
        #1 reset = 0;
        stall_in = 0;
        load_word(32'h00500093, 32'hC0);
        chk("post_rs_imm", imm, 32'h00000005);
        chk("post_rs_pc", out_pc, 32'hC0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end

endmodule
